// File: rtl/fnd_ctrl.sv
//=============================================================================
// fnd_ctrl
//
// Driver for the microwave timer's 4-digit, time-multiplexed 7-segment (FND)
// display. The display is common-anode, so everything is active-low.
// The remaining cook time arrives as binary minutes and seconds and is shown
// as MM.SS. While 'done' is high, the word "donE" is shown instead.
//
// A free-running scan counter produces a one-cycle tick every SCAN_DIV
// clocks. Each tick advances the digit select through
// seconds-ones -> seconds-tens -> minutes-ones -> minutes-tens.
// The segment pattern and the common select for the current digit are
// decoded combinationally. Both are then registered together, so a segment
// pattern can never be paired with the wrong digit.
//
// Parameters
//   CLK_FREQ  input clock frequency in Hz
//   SCAN_HZ   digit advance rate in Hz (SCAN_DIV = CLK_FREQ / SCAN_HZ)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset; blanks the display
//   done      cook-complete flag; 1 shows "donE"
//   sec       seconds remaining, binary (60..63 are shown as decoded)
//   min       minutes remaining, binary (60..63 are shown as decoded)
//   fnd_data  segment drive {dp,g,f,e,d,c,b,a}, active-low
//   fnd_com   digit common select, active-low one-hot, bit0 = rightmost
//=============================================================================
module fnd_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic [7:0] fnd_data,
    output logic [3:0] fnd_com
);

    localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Active-low segment codes, {dp,g,f,e,d,c,b,a}, with dp off
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_O     = 8'hA3;
    localparam logic [7:0] SEG_N     = 8'hAB;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] DP_CLEAR  = 8'h7F;

    // Digit positions, named by what they show in MM.SS mode
    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_e;

    logic [CNT_W-1:0] scan_cnt;
    logic             scan_tick;
    digit_e           sel;
    digit_e           sel_next;

    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;

    logic [7:0] seg_code;
    logic       dp_on;
    logic [7:0] data_next;
    logic [3:0] com_next;

    // Decimal digit to active-low segment pattern. The tens digit never
    // exceeds 6, and the ones digit never exceeds 9, so the blank default
    // only guards against unreachable codes.
    function automatic logic [7:0] digit_seg(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // The tick fires on the last count of each scan period
    always_comb begin
        scan_tick = (scan_cnt == CNT_LAST);
    end

    // Scan period counter, wrapping at SCAN_DIV
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit rotation order, right to left
    always_comb begin
        sel_next = DIG_SEC_ONES;
        case (sel)
            DIG_SEC_ONES: sel_next = DIG_SEC_TENS;
            DIG_SEC_TENS: sel_next = DIG_MIN_ONES;
            DIG_MIN_ONES: sel_next = DIG_MIN_TENS;
            DIG_MIN_TENS: sel_next = DIG_SEC_ONES;
            default:      sel_next = DIG_SEC_ONES;
        endcase
    end

    // Digit select register; moves once per scan period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= DIG_SEC_ONES;
        end else if (scan_tick) begin
            sel <= sel_next;
        end
    end

    // Binary to decimal split of the raw 6-bit inputs
    always_comb begin
        sec_ones = 4'(sec % 6'd10);
        sec_tens = 4'(sec / 6'd10);
        min_ones = 4'(min % 6'd10);
        min_tens = 4'(min / 6'd10);
    end

    // Pick the pattern and common for the current digit. The MM.SS
    // separator is the dp of the minutes-ones digit. It stays dark while
    // the message is shown.
    always_comb begin
        seg_code = SEG_BLANK;
        dp_on    = 1'b0;
        com_next = 4'b1111;
        case (sel)
            DIG_SEC_ONES: begin
                com_next = 4'b1110;
                seg_code = done ? SEG_E : digit_seg(sec_ones);
            end
            DIG_SEC_TENS: begin
                com_next = 4'b1101;
                seg_code = done ? SEG_N : digit_seg(sec_tens);
            end
            DIG_MIN_ONES: begin
                com_next = 4'b1011;
                seg_code = done ? SEG_O : digit_seg(min_ones);
                dp_on    = ~done;
            end
            DIG_MIN_TENS: begin
                com_next = 4'b0111;
                seg_code = done ? SEG_D : digit_seg(min_tens);
            end
            default: begin
                com_next = 4'b1111;
                seg_code = SEG_BLANK;
            end
        endcase
        data_next = dp_on ? (seg_code & DP_CLEAR) : seg_code;
    end

    // Output register. Segments and common load on the same edge.
    // Reset blanks the display immediately, with no clock needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_com  <= 4'b1111;
            fnd_data <= SEG_BLANK;
        end else begin
            fnd_com  <= com_next;
            fnd_data <= data_next;
        end
    end

endmodule

// File: tb/tb_fnd_ctrl.sv
//=============================================================================
// tb_fnd_ctrl
//
// Self-checking bench for fnd_ctrl. The bench runs the scan with a short
// period (SCAN_DIV = 10) so that whole frames fit in a few hundred cycles.
//
// The reference model works from the display's observable behaviour:
// - After reset release, clock edge n shows the digit at position
//   ((n-1)/SCAN_DIV) mod 4.
// - Its contents follow from decimal arithmetic on the inputs present at
//   that edge.
//=============================================================================
module tb_fnd_ctrl;

    localparam int DIV    = 10;
    localparam int FRAME  = 4 * DIV;
    localparam int TMO    = 8 * DIV;

    logic       clk;
    logic       rst;
    logic       done;
    logic [5:0] sec;
    logic [5:0] min;
    logic [7:0] fnd_data;
    logic [3:0] fnd_com;

    int errors = 0;
    int checks = 0;
    int edge_cnt;

    logic [7:0] num_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    // letters by position: pos0 'E', pos1 'n', pos2 'o', pos3 'd'
    logic [7:0] msg_tab [4] = '{8'h86, 8'hAB, 8'hA3, 8'hA1};
    logic [3:0] com_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    fnd_ctrl #(
        .CLK_FREQ(1000),
        .SCAN_HZ (100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .done    (done),
        .sec     (sec),
        .min     (min),
        .fnd_data(fnd_data),
        .fnd_com (fnd_com)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Digit position shown after the current edge count
    function automatic int exp_pos();
        return ((edge_cnt - 1) / DIV) % 4;
    endfunction

    // Expected segment byte for a position, computed from the inputs
    function automatic logic [7:0] model_seg(int pos, logic d, int s, int m);
        int val;
        logic [7:0] code;
        if (d) return msg_tab[pos];
        case (pos)
            0:       val = s % 10;
            1:       val = s / 10;
            2:       val = m % 10;
            default: val = m / 10;
        endcase
        code = num_tab[val];
        if (pos == 2) code = code & 8'h7F;
        return code;
    endfunction

    task automatic test_reset();
        rst = 1'b1; done = 1'b0; sec = 6'd0; min = 6'd0;
        #20;
        checks++;
        if (fnd_com !== 4'b1111) begin
            errors++; $display("[TB] FAIL reset_com: got %b want 1111", fnd_com);
        end
        checks++;
        if (fnd_data !== 8'hFF) begin
            errors++; $display("[TB] FAIL reset_data: got %h want FF", fnd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fnd_com !== 4'b1110) begin
            errors++; $display("[TB] FAIL first_edge_com: got %b want 1110", fnd_com);
        end
        checks++;
        if (fnd_data !== 8'hC0) begin
            errors++; $display("[TB] FAIL first_edge_data: got %h want C0", fnd_data);
        end
    endtask

    task automatic test_time_display();
        logic [7:0] lit [4] = '{8'hC0, 8'hB0, 8'h79, 8'hC0};
        logic [3:0] prev_com;
        int run_len;
        int runs_seen;
        int pos;
        min = 6'd1; sec = 6'd30;
        prev_com = fnd_com;
        run_len = 0;
        runs_seen = 0;
        repeat (5 * DIV) begin
            @(negedge clk);
            pos = exp_pos();
            checks++;
            if (fnd_com !== com_tab[pos]) begin
                errors++; $display("[TB] FAIL time_com: got %b want %b", fnd_com, com_tab[pos]);
            end
            checks++;
            if (fnd_data !== lit[pos]) begin
                errors++; $display("[TB] FAIL time_data pos%0d: got %h want %h", pos, fnd_data, lit[pos]);
            end
            if (fnd_com === prev_com) begin
                run_len++;
            end else begin
                // the first run started before this task, so it is partial
                if (runs_seen > 0) begin
                    checks++;
                    if (run_len !== DIV) begin
                        errors++; $display("[TB] FAIL slot_length: got %0d want %0d", run_len, DIV);
                    end
                end
                runs_seen++;
                run_len = 1;
                prev_com = fnd_com;
            end
        end
    endtask

    task automatic test_input_change();
        logic [3:0] prev_com;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(exp_pos() == 0 && ((edge_cnt - 1) % DIV) <= DIV - 3) && guard < TMO) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= TMO) begin
            errors++; $display("[TB] FAIL input_change_wait: got timeout want sel0 slot");
        end
        prev_com = fnd_com;
        sec = 6'd29;
        @(negedge clk);
        checks++;
        if (fnd_data !== 8'h90) begin
            errors++; $display("[TB] FAIL input_change_data: got %h want 90", fnd_data);
        end
        checks++;
        if (fnd_com !== prev_com || fnd_com !== 4'b1110) begin
            errors++; $display("[TB] FAIL input_change_com: got %b want 1110", fnd_com);
        end
    endtask

    task automatic test_done_message();
        int pos;
        done = 1'b1; min = 6'd0; sec = 6'd0;
        repeat (FRAME + 3) begin
            @(negedge clk);
            pos = exp_pos();
            checks++;
            if (fnd_com !== com_tab[pos]) begin
                errors++; $display("[TB] FAIL done_com: got %b want %b", fnd_com, com_tab[pos]);
            end
            checks++;
            if (fnd_data !== msg_tab[pos]) begin
                errors++; $display("[TB] FAIL done_data pos%0d: got %h want %h", pos, fnd_data, msg_tab[pos]);
            end
            checks++;
            if (fnd_data[7] !== 1'b1) begin
                errors++; $display("[TB] FAIL done_dp: got %b want 1", fnd_data[7]);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_boundary();
        logic [7:0] lit59 [4] = '{8'h90, 8'h92, 8'h10, 8'h92};
        int pos;
        min = 6'd59; sec = 6'd59;
        repeat (FRAME + 1) begin
            @(negedge clk);
            pos = exp_pos();
            checks++;
            if (fnd_data !== lit59[pos] || fnd_com !== com_tab[pos]) begin
                errors++;
                $display("[TB] FAIL boundary_5959 pos%0d: got %h/%b want %h/%b",
                         pos, fnd_data, fnd_com, lit59[pos], com_tab[pos]);
            end
        end
        min = 6'd0; sec = 6'd63;
        repeat (FRAME + 1) begin
            @(negedge clk);
            pos = exp_pos();
            checks++;
            if (fnd_data !== model_seg(pos, 1'b0, 63, 0)) begin
                errors++;
                $display("[TB] FAIL boundary_sec63 pos%0d: got %h want %h",
                         pos, fnd_data, model_seg(pos, 1'b0, 63, 0));
            end
            if (pos == 1) begin
                checks++;
                if (fnd_data !== 8'h82) begin
                    errors++; $display("[TB] FAIL sec63_tens: got %h want 82", fnd_data);
                end
            end
            if (pos == 0) begin
                checks++;
                if (fnd_data !== 8'hB0) begin
                    errors++; $display("[TB] FAIL sec63_ones: got %h want B0", fnd_data);
                end
            end
        end
    endtask

    task automatic test_random();
        int pos;
        logic [7:0] exp_data;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            pos = exp_pos();
            exp_data = model_seg(pos, done, int'(sec), int'(min));
            checks++;
            if (fnd_data !== exp_data || fnd_com !== com_tab[pos]) begin
                errors++;
                $display("[TB] FAIL random cyc%0d: got %h/%b want %h/%b (done=%b min=%0d sec=%0d)",
                         i, fnd_data, fnd_com, exp_data, com_tab[pos], done, min, sec);
            end
            if ($urandom_range(0, 3) == 0) sec  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) min  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) done = ~done;
        end
        done = 1'b0;
    endtask

    task automatic test_async_reset();
        int guard;
        int pos;
        min = 6'd12; sec = 6'd34;
        guard = 0;
        @(negedge clk);
        while (exp_pos() != 2 && guard < TMO) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= TMO) begin
            errors++; $display("[TB] FAIL async_wait: got timeout want sel2 slot");
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
            errors++; $display("[TB] FAIL async_blank: got %b/%h want 1111/FF", fnd_com, fnd_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * DIV) begin
            @(negedge clk);
            pos = exp_pos();
            checks++;
            if (fnd_com !== com_tab[pos] || fnd_data !== model_seg(pos, done, int'(sec), int'(min))) begin
                errors++;
                $display("[TB] FAIL async_resume edge%0d: got %b/%h want %b/%h",
                         edge_cnt, fnd_com, fnd_data, com_tab[pos], model_seg(pos, done, int'(sec), int'(min)));
            end
            if (edge_cnt <= DIV) begin
                checks++;
                if (fnd_com !== 4'b1110) begin
                    errors++; $display("[TB] FAIL async_first_slot: got %b want 1110", fnd_com);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] fnd_ctrl bench start");
        test_reset();
        test_time_display();
        test_input_change();
        test_done_message();
        test_boundary();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
